// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. Owns the program counter, talks to an
// instruction memory that allows one request in flight at a time, buffers
// one returned instruction while ID is stalled, and offers instructions to
// ID through a valid/ready_go/allow_in handshake. Redirects from EX take
// priority over everything else. A response that was already in flight when
// the redirect arrived is swallowed so that ID never sees it.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   jump_req        redirect pulse from EX
//   jump_addr       redirect target (low two bits ignored)
//   inst_req        instruction memory request
//   inst_addr       request address
//   inst_gnt        memory accepts the request this cycle
//   inst_rvalid     response valid (at least one cycle after the grant)
//   inst_rdata      response data
//   pc_if           PC of the instruction offered to ID
//   instruction_if  instruction offered to ID
//   valid_if        stage holds a live fetch
//   ready_go_if     instruction data is available this cycle
//   allow_in_id     ID accepts this cycle
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int unsigned           BUS_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  jump_req,
   input  logic [BUS_WIDTH-1:0]  jump_addr,
   output logic                  inst_req,
   output logic [BUS_WIDTH-1:0]  inst_addr,
   input  logic                  inst_gnt,
   input  logic                  inst_rvalid,
   input  logic [DATA_WIDTH-1:0] inst_rdata,
   output logic [BUS_WIDTH-1:0]  pc_if,
   output logic [DATA_WIDTH-1:0] instruction_if,
   output logic                  valid_if,
   output logic                  ready_go_if,
   input  logic                  allow_in_id
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t                  state, state_nxt;
   logic [BUS_WIDTH-1:0]    pc, pc_nxt;
   logic [BUS_WIDTH-1:0]    pc_plus4;
   logic [BUS_WIDTH-1:0]    jump_target;
   logic [DATA_WIDTH-1:0]   hold_inst;
   logic                    hold_load;
   logic                    xfer;

   assign pc_plus4    = pc + BUS_WIDTH'(4);
   assign jump_target = {jump_addr[BUS_WIDTH-1:2], 2'b00};

   // A redirect kills whatever is currently offered to ID in the same cycle.
   assign valid_if       = (state == S_WAIT || state == S_HOLD) && !jump_req;
   assign ready_go_if    = valid_if && (state == S_HOLD || inst_rvalid);
   assign xfer           = ready_go_if && allow_in_id;
   assign pc_if          = pc;
   assign instruction_if = (state == S_WAIT) ? inst_rdata : hold_inst;

   // Issuing the next request in the handoff cycle keeps one instruction
   // per cycle when the memory answers one cycle after the grant.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      inst_req  = 1'b0;
      inst_addr = pc;
      if (!jump_req) begin
         if (state == S_REQ) begin
            inst_req = 1'b1;
         end else if (xfer) begin
            inst_req  = 1'b1;
            inst_addr = pc_plus4;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      hold_load = 1'b0;
      if (jump_req) begin
         pc_nxt = jump_target;
         // Only a request still awaiting its response needs draining; a
         // response arriving with the jump is simply dropped here.
         if ((state == S_WAIT || state == S_DISCARD) && !inst_rvalid) begin
            state_nxt = S_DISCARD;
         end else begin
            state_nxt = S_REQ;
         end
      end else begin
         case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
               if (inst_gnt) state_nxt = S_WAIT;
            end
            S_WAIT, S_HOLD: begin
               if (xfer) begin
                  pc_nxt    = pc_plus4;
                  state_nxt = inst_gnt ? S_WAIT : S_REQ;
               end else if (state == S_WAIT && inst_rvalid) begin
                  hold_load = 1'b1;
                  state_nxt = S_HOLD;
               end
            end
            S_DISCARD: begin
               if (inst_rvalid) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         hold_inst <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples
         // the pre-edge values regardless of statement order.
         state <= state_nxt;
         pc    <= pc_nxt;
         if (hold_load) hold_inst <= inst_rdata;
      end
   end

   // The memory keeps at most one request outstanding and only answers a
   // granted request, so no response can show up while requesting or holding.
   single_outstanding_a : assert property (
      @(posedge clk) disable iff (!rst_n)
      !(inst_rvalid && (state == S_REQ || state == S_HOLD))
   );

endmodule
